// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   MEM_WORDS_DEFAULT : default data memory depth in 32-bit words
//   state_t           : arbiter sequencing states
//   addr_rejected     : true for a misaligned or out-of-range byte address
package dmem_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // limit is the first illegal byte address (4 * depth in words)
    function automatic logic addr_rejected(input logic [31:0] addr,
                                           input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data memory port.
//   req/we/addr/wdata 0,1 : requester commands
//   ack0/ack1/err/rdata   : completion responses
//   mem_*                 : data memory side (mem_rdata is combinational)
// slave  : arbiter side
// master : requesters plus memory model side
interface dmem_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, ack1, err, rdata,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, ack1, err, rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker.
//   req0, req1 : requests
//   last       : id of the previously granted port
//   grant      : id of the winning port (meaningful only when valid)
//   valid      : at least one request present
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted command runs IDLE -> ACCESS -> RESP, acking in RESP.
//   clk, reset : clock and synchronous active-high reset
//   bus        : requester commands/responses and the memory port
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; picks a requester and latches its command
// ACCESS | drives the memory with the latched command (unless rejected)
// RESP   | pulses the granted port's ack with err/rdata
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter bit          RR_RESET  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    state_t      state_q, state_d;
    logic        last_q;
    logic        port_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        grant;
    logic        grant_valid;
    logic        rejected;
    logic        ack0, ack1, err, mem_write, mem_read;

    rr_arbiter2 u_rr (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last_q),
        .grant (grant),
        .valid (grant_valid)
    );

    assign rejected = addr_rejected(addr_q, ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= RR_RESET;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) begin
                port_q  <= grant;
                last_q  <= grant;
                we_q    <= grant ? bus.we1    : bus.we0;
                addr_q  <= grant ? bus.addr1  : bus.addr0;
                wdata_q <= grant ? bus.wdata1 : bus.wdata0;
            end
            // rdata is non-zero only during the RESP cycle of a good read
            if (state_q == ACCESS) begin
                rdata_q <= (!we_q && !rejected) ? bus.mem_rdata : '0;
            end else begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err       = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = RESP;
                // gating with reset keeps an aborted write off the memory
                if (!rejected && !reset) begin
                    mem_write = we_q;
                    mem_read  = ~we_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                ack0    = ~port_q;
                ack1    = port_q;
                err     = rejected;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack0      = ack0;
    assign bus.ack1      = ack1;
    assign bus.err       = err;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_write = mem_write;
    assign bus.mem_read  = mem_read;

endmodule
